// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file burst reader.
// Consumers: regfile_burst_reader, rd_out_stage.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE_ONLY} rd_state_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // Requests larger than the file are trimmed to one full pass.
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
        localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_REGS);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction
endpackage

// File: rtl/rd_out_stage.sv
// Output word register with valid flag for the burst reader.
// Load captures a new word; clear drops valid; otherwise everything holds.
module rd_out_stage
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/regfile_burst_reader.sv
// Streams a contiguous, wrapping range of register-file words over valid/ready, then pulses done.
// Optional macro ZERO_REG31_EN: reads of the top register return zero (hardwired-zero register).
//
// state     | meaning
// IDLE      | waiting for start; done pulse (if any) is visible here
// READ      | loading one word per accepted slot, walking addr upward
// DRAIN     | last word loaded, waiting for its handshake
// DONE_ONLY | zero-length burst, emit done without any word
module regfile_burst_reader
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    rd_state_t         r_state;
    reg_addr_t         r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_done;
    logic              w_load;
    logic              w_clear;
    logic [ADDR_W:0]   w_count_clamped;
    logic [DATA_W-1:0] w_load_data;

    assign w_count_clamped = clamp_count(count);
    // A slot is free when nothing is held or the held word is being taken this cycle.
    assign w_load  = (r_state == READ) && (!out_valid || out_ready);
    assign w_clear = (r_state == DRAIN) && out_valid && out_ready;

`ifdef ZERO_REG31_EN
    assign w_load_data = (r_addr == reg_addr_t'(NUM_REGS-1)) ? '0 : rd_data;
`else
    assign w_load_data = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr      <= start_addr;
                        r_remaining <= w_count_clamped;
                        r_state     <= (w_count_clamped == '0) ? DONE_ONLY : READ;
                    end
                end
                READ: begin
                    if (w_load) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (ADDR_W+1)'(1))
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_clear) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DONE_ONLY: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rd_out_stage u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_data  (w_load_data),
        .o_data  (out_data),
        .o_valid (out_valid)
    );

    assign rd_addr = r_addr;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
endmodule

// File: tb/tb_regfile_burst_reader.sv
// Self-checking bench for regfile_burst_reader: directed burst table, hand-written
// corner sequences and random bursts against a queue-based reference model.
module tb_regfile_burst_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  count;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data = 64'h100 + {59'd0, rd_addr};

    regfile_burst_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [63:0] model_word(input int a);
`ifdef ZERO_REG31_EN
        if (a == 31) return 64'h0;
`endif
        return 64'h100 + 64'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode: 0 ready always, 1 stall 3 cycles on the second word, 2 random ready
    task automatic run_burst(input int sa, input int cnt, input int mode,
                             input bit prestarted, input bit busy_start,
                             input bit chain, input int chain_sa, input int chain_cnt,
                             output int n_hs, output logic [63:0] first_w,
                             output logic [63:0] last_w);
        logic [63:0] q[$];
        int  n;
        int  last_hs;
        int  stall;
        int  hold_cnt;
        bit  got_done;
        bit  rdy;
        n = (cnt > 32) ? 32 : cnt;
        for (int i = 0; i < n; i++) q.push_back(model_word((sa + i) % 32));
        n_hs = 0; first_w = '0; last_w = '0;
        last_hs = -1; stall = 0; hold_cnt = 0; got_done = 0;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1; start_addr = 5'(sa); count = 6'(cnt);
        end
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy_start && cyc == 2) begin
                start = 1'b1; start_addr = 5'd7; count = 6'd5;
            end
            if (cyc == 0) begin
                chk("latency_no_valid_yet", {63'd0, out_valid}, 64'd0);
                chk("busy_after_start", {63'd0, busy}, 64'd1);
            end
            if (cyc == 1 && n > 0) chk("latency_first_valid", {63'd0, out_valid}, 64'd1);
            if (done) begin
                got_done = 1;
                chk("done_all_words", 64'(q.size()), 64'd0);
                chk("done_timing", 64'(cyc), (n == 0) ? 64'd1 : 64'(last_hs + 1));
                chk("busy_low_at_done", {63'd0, busy}, 64'd0);
                chk("valid_low_at_done", {63'd0, out_valid}, 64'd0);
                out_ready = 1'b0;
                if (chain) begin
                    start = 1'b1; start_addr = 5'(chain_sa); count = 6'(chain_cnt);
                end
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("extra_word", out_data, 64'hx);
                    rdy = 1'b1;
                end else begin
                    chk("stream_word", out_data, q[0]);
                    if (n_hs == 1) hold_cnt++;
                    case (mode)
                        0: rdy = 1'b1;
                        1: begin
                            rdy = !(n_hs == 1 && stall < 3);
                            if (!rdy) stall++;
                        end
                        default: rdy = ($urandom_range(0, 3) != 0);
                    endcase
                    if (rdy) begin
                        if (n_hs == 0) first_w = out_data;
                        last_w = out_data;
                        void'(q.pop_front());
                        n_hs++;
                        last_hs = cyc;
                    end
                end
                out_ready = rdy;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout: got no done within budget expected done");
        end
        if (mode == 1) chk("stall_hold_cycles", 64'(hold_cnt), 64'd4);
    endtask

    typedef struct {
        int          sa;
        int          cnt;
        int          mode;
        int          exp_n;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
    } vec_t;

    vec_t        vecs[6];
    int          n_hs;
    logic [63:0] fw, lw;

    initial begin
        vecs[0] = '{3, 4, 0, 4, 64'h103, 64'h106};
        vecs[1] = '{3, 4, 1, 4, 64'h103, 64'h106};
        vecs[2] = '{30, 4, 0, 4, 64'h11E, 64'h101};
        vecs[3] = '{5, 33, 0, 32, 64'h105, 64'h104};
        vecs[4] = '{9, 0, 0, 0, 64'h0, 64'h0};
`ifdef ZERO_REG31_EN
        vecs[5] = '{31, 1, 0, 1, 64'h0, 64'h0};
`else
        vecs[5] = '{31, 1, 0, 1, 64'h11F, 64'h11F};
`endif
        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_data", out_data, 64'd0);
        chk("reset_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_burst(vecs[i].sa, vecs[i].cnt, vecs[i].mode, 0, 0, 0, 0, 0, n_hs, fw, lw);
            chk("table_handshakes", 64'(n_hs), 64'(vecs[i].exp_n));
            chk("table_first_word", fw, vecs[i].exp_first);
            chk("table_last_word", lw, vecs[i].exp_last);
        end

        // start while busy is ignored; nothing runs afterwards
        run_burst(3, 4, 0, 0, 1, 0, 0, 0, n_hs, fw, lw);
        chk("busy_start_handshakes", 64'(n_hs), 64'd4);
        repeat (3) @(negedge clk);
        chk("busy_start_no_second", {63'd0, busy}, 64'd0);

        // start in the done cycle is accepted
        run_burst(3, 4, 0, 0, 0, 1, 10, 3, n_hs, fw, lw);
        run_burst(10, 3, 0, 1, 0, 0, 0, 0, n_hs, fw, lw);
        chk("chain_handshakes", 64'(n_hs), 64'd3);
        chk("chain_first_word", fw, 64'h10A);

        // reset after two words abandons the burst without done
        @(negedge clk);
        start = 1'b1; start_addr = 5'd0; count = 6'd8; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done || out_valid) seen++;
            end
            chk("midreset_quiet", 64'(seen), 64'd0);
        end

        for (int r = 0; r < 20; r++) begin
            int sa_r, cnt_r;
            sa_r  = $urandom_range(0, 31);
            cnt_r = $urandom_range(0, 34);
            run_burst(sa_r, cnt_r, 2, 0, 0, 0, 0, 0, n_hs, fw, lw);
            chk("rand_handshakes", 64'(n_hs), 64'((cnt_r > 32) ? 32 : cnt_r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
